hazard_scoreboard: RTL
======================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the fixed forwarding unit and load-use hazard detector of the 5-stage MIPS/DLX pipeline.
- Keeps a shift-register scoreboard of in-flight destination registers for NUM_STAGES stages past ID.
- At ID, decides stall or issue. On issue, registers per-operand forward selects that the EX stage consumes on the next cycle.
- Supports deeper pipelines and configurable load latency. Sits between the IF/ID latch and the ID/EX latch.

Parameters:
NUM_STAGES, 3, tracked stages after ID (entry 0 = EX, 1 = MEM, 2 = WB, ...); legal range 2..8
REG_ADDR_W, 5, register specifier width
LOAD_LAT, 2, first entry index + 1 from which load data can be forwarded (load forwardable from entry >= LOAD_LAT-1); legal range 1..NUM_STAGES
SEL_W, $clog2(NUM_STAGES+1), forward select width (derived, not overridden)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
id_valid  in  1  valid instruction in ID
id_rs  in  REG_ADDR_W  source A specifier
id_rt  in  REG_ADDR_W  source B specifier
id_uses_rs  in  1  instruction reads rs
id_uses_rt  in  1  instruction reads rt
id_rd  in  REG_ADDR_W  destination specifier
id_reg_write  in  1  instruction writes id_rd
id_mem_read  in  1  instruction is a load
flush  in  1  squash the ID instruction (taken branch/jump)
stall  out  1  combinational; hold PC and IF/ID, insert bubble
issue  out  1  combinational; the ID instruction enters EX at the next edge
fwd_sel_a  out  SEL_W  registered; 0 = register file, k = result of entry k-1 at issue time
fwd_sel_b  out  SEL_W  registered; same encoding for operand B
ex_valid  out  1  registered; EX holds a real (non-bubble) instruction

Behaviour:
- State: NUM_STAGES entries, each holding {v, rd, ld}. Every clock all entries shift (entry i -> i+1); the oldest entry is discarded.
- Entry 0 load:
  - issue=1: loads {id_reg_write && id_rd!=0, id_rd, id_mem_read}.
  - otherwise: loads a bubble {0, 0, 0}.
- Match, per source s (rs or rt): entry i matches when uses_s && v_i && rd_i==s && s!=0.
  - The youngest match (lowest i) governs.
  - No match gives select 0. Register 0 never matches.
- Hazard: youngest match has ld=1 and i < LOAD_LAT-1.
- stall = id_valid && !flush && (hazard_a || hazard_b). Stall is purely combinational from the entries and ID inputs; 0 when id_valid=0.
- issue = id_valid && !flush && !stall.
- At each edge:
  - issue=1: fwd_sel_x <= youngest match index + 1 (or 0), ex_valid <= 1.
  - issue=0: fwd_sel_a/b <= 0, ex_valid <= 0.
- Stall persistence: a stall lasts until the offending load shifts to entry LOAD_LAT-1. With the defaults this is exactly 1 cycle.
- Latency: decision in the same cycle; selects valid in the cycle after issue.
- Flush and stall together: flush wins. Bubble inserted, stall=0, older entries untouched.
- Reset (reset=0 at an edge, including mid-stall):
  - all entries invalid;
  - fwd_sel_a = fwd_sel_b = 0, ex_valid = 0;
  - stall = 0 from the next cycle, because entries are cleared.
- A match beyond entry NUM_STAGES-1 reads the register file; the register file must write before it reads.

Optional Feature:
- Macro: HAZARD_STALL_COUNT_EN.
- Defined:
  - adds output stall_count, 32-bit, registered;
  - +1 on every edge where stall=1, wraps at 2^32-1 -> 0;
  - cleared by reset;
  - flush cycles are not counted.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset for 2 cycles with id_valid=1 and random inputs -> stall=0, fwd_sel_a=fwd_sel_b=0, ex_valid=0 after release.
- ALU chain: add r3 (rd=3), then sub using rs=3 -> no stall. Second instruction gets fwd_sel_a=1. A third instruction using rt=3 gets fwd_sel_b=2.
- Load-use, defaults: lw rd=5, then add rs=5 -> stall=1 for exactly 1 cycle, bubble in EX (ex_valid=0). The add then issues with fwd_sel_a=2.
- Deep load latency: NUM_STAGES=5, LOAD_LAT=3, lw rd=7, then consumer rt=7 -> stall 2 cycles, then fwd_sel_b=3.
- Youngest wins and r0: two writers to r4 in entries 0 and 1 -> consumer fwd_sel=1. Consumer of rd=0 after a writer with rd=0 -> sel 0, no stall.
- Flush during load-use stall: flush=1 -> stall=0, bubble inserted, stall_count (with HAZARD_STALL_COUNT_EN) not incremented. Reset asserted mid-stall clears all entries.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Stall/forward decision unit at ID, tracking in-flight destinations over NUM_STAGES stages.
// Optional feature macro: HAZARD_STALL_COUNT_EN adds a 32-bit stall_count output.
module hazard_scoreboard #(
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned LOAD_LAT   = 2,
  localparam int unsigned SEL_W     = $clog2(NUM_STAGES + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  flush,
  output logic                  stall,
  output logic                  issue,
  output logic [SEL_W-1:0]      fwd_sel_a,
  output logic [SEL_W-1:0]      fwd_sel_b,
  output logic                  ex_valid
`ifdef HAZARD_STALL_COUNT_EN
  ,
  output logic [31:0]           stall_count
`endif
);

  // Entry 0 is EX; higher indices are older instructions.
  logic [NUM_STAGES-1:0]                 r_v;
  logic [NUM_STAGES-1:0]                 r_ld;
  logic [NUM_STAGES-1:0][REG_ADDR_W-1:0] r_rd;

  logic [SEL_W-1:0] r_fwd_sel_a;
  logic [SEL_W-1:0] r_fwd_sel_b;
  logic             r_ex_valid;

  logic [SEL_W-1:0]      w_sel_a;
  logic [SEL_W-1:0]      w_sel_b;
  logic                  w_found_a;
  logic                  w_found_b;
  logic                  w_haz_a;
  logic                  w_haz_b;
  logic                  w_stall;
  logic                  w_issue;
  logic                  w_v_in;
  logic                  w_ld_in;
  logic [REG_ADDR_W-1:0] w_rd_in;

  // Youngest match wins: the first hit while scanning from entry 0 locks the result.
  always_comb begin
    w_sel_a   = '0;
    w_found_a = 1'b0;
    w_haz_a   = 1'b0;
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      if (!w_found_a && id_uses_rs && r_v[i] && (r_rd[i] == id_rs) && (id_rs != '0)) begin
        w_found_a = 1'b1;
        w_sel_a   = SEL_W'(i + 1);
        w_haz_a   = r_ld[i] && (i < LOAD_LAT - 1);
      end
    end
  end

  always_comb begin
    w_sel_b   = '0;
    w_found_b = 1'b0;
    w_haz_b   = 1'b0;
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      if (!w_found_b && id_uses_rt && r_v[i] && (r_rd[i] == id_rt) && (id_rt != '0)) begin
        w_found_b = 1'b1;
        w_sel_b   = SEL_W'(i + 1);
        w_haz_b   = r_ld[i] && (i < LOAD_LAT - 1);
      end
    end
  end

  always_comb begin
    w_stall = id_valid && !flush && (w_haz_a || w_haz_b);
    w_issue = id_valid && !flush && !w_stall;
    w_v_in  = w_issue && id_reg_write && (id_rd != '0);
    w_ld_in = w_issue && id_mem_read;
    w_rd_in = w_issue ? id_rd : '0;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_v         <= '0;
      r_ld        <= '0;
      r_rd        <= '0;
      r_fwd_sel_a <= '0;
      r_fwd_sel_b <= '0;
      r_ex_valid  <= 1'b0;
    end else begin
      r_v         <= {r_v[NUM_STAGES-2:0], w_v_in};
      r_ld        <= {r_ld[NUM_STAGES-2:0], w_ld_in};
      r_rd        <= {r_rd[NUM_STAGES-2:0], w_rd_in};
      r_fwd_sel_a <= w_issue ? w_sel_a : '0;
      r_fwd_sel_b <= w_issue ? w_sel_b : '0;
      r_ex_valid  <= w_issue;
    end
  end

`ifdef HAZARD_STALL_COUNT_EN
  logic [31:0] r_stall_count;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_stall_count <= '0;
    end else if (w_stall) begin
      r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign stall_count = r_stall_count;
`endif

  assign stall     = w_stall;
  assign issue     = w_issue;
  assign fwd_sel_a = r_fwd_sel_a;
  assign fwd_sel_b = r_fwd_sel_b;
  assign ex_valid  = r_ex_valid;

endmodule
